// File: rtl/ev_word_loader_pkg.sv
// Shared execution-event types: region enum, region lengths, event layout.
package ev_word_loader_pkg;

  localparam int unsigned EV_DATA_LEN   = 7;  // dataLength_u32
  localparam int unsigned EV_SHARED_LEN = 4;  // sharedLength_u32
  localparam int unsigned EV_THREAD_LEN = 4;  // threadLength_u32 (opcode words live here)
  localparam int unsigned EV_IDX_W      = 3;  // covers the largest region length

  typedef enum logic [1:0] {
    EV_REG_DATA   = 2'd0,
    EV_REG_SHARED = 2'd1,
    EV_REG_THREAD = 2'd2,
    EV_REG_RSVD   = 2'd3
  } ev_region_e;

  typedef struct packed {
    logic [EV_DATA_LEN-1:0][31:0] u32;
  } ev_data_t;

  typedef struct packed {
    logic [EV_SHARED_LEN-1:0][31:0] u32;
  } ev_shared_t;

  typedef struct packed {
    logic [EV_THREAD_LEN-1:0][31:0] u32;
  } ev_thread_t;

  // data occupies the low bits, then shared, then thread.
  typedef struct packed {
    ev_thread_t thread;
    ev_shared_t shared;
    ev_data_t   data;
  } ex_ev_t;

endpackage

// File: rtl/ev_buf_slot.sv
// One event buffer: clear-on-first-write, indexed word write, range check, error bit.
// Ports: wr_en_i/clear_i write strobe and first-word flag; region_i/index_i/word_i
// word target and value; ev_o/err_o buffered event and its dropped-word flag.
module ev_buf_slot
  import ev_word_loader_pkg::*;
#(
  parameter int unsigned IDX_W = EV_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic             clear_i,
  input  logic [1:0]       region_i,
  input  logic [IDX_W-1:0] index_i,
  input  logic [31:0]      word_i,
  output ex_ev_t           ev_o,
  output logic             err_o
);

  localparam int unsigned DATA_SEL_W   = $clog2(EV_DATA_LEN);
  localparam int unsigned SHARED_SEL_W = $clog2(EV_SHARED_LEN);
  localparam int unsigned THREAD_SEL_W = $clog2(EV_THREAD_LEN);

  ex_ev_t ev_q, ev_d;
  logic   err_q, err_d;

  // Next buffer contents: optional clear, then either the write or the error flag.
  always_comb begin
    ev_d  = ev_q;
    err_d = err_q;
    if (wr_en_i) begin
      if (clear_i) begin
        ev_d  = '0;
        err_d = 1'b0;
      end
      case (ev_region_e'(region_i))
        EV_REG_DATA: begin
          if (32'(index_i) < EV_DATA_LEN) ev_d.data.u32[DATA_SEL_W'(index_i)] = word_i;
          else                            err_d = 1'b1;
        end
        EV_REG_SHARED: begin
          if (32'(index_i) < EV_SHARED_LEN) ev_d.shared.u32[SHARED_SEL_W'(index_i)] = word_i;
          else                              err_d = 1'b1;
        end
        EV_REG_THREAD: begin
          if (32'(index_i) < EV_THREAD_LEN) ev_d.thread.u32[THREAD_SEL_W'(index_i)] = word_i;
          else                              err_d = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q  <= '0;
      err_q <= 1'b0;
    end else begin
      ev_q  <= ev_d;
      err_q <= err_d;
    end
  end

  assign ev_o  = ev_q;
  assign err_o = err_q;

endmodule

// File: rtl/ev_word_loader.sv
// Assembles tagged 32-bit words into ex_ev_t events; two ping-pong buffers feed
// a valid/ready output. Ports: in_* word stream (valid/ready, region, index, word,
// last); out_* completed event (valid/ready, event, dropped-word error flag).
module ev_word_loader
  import ev_word_loader_pkg::*;
#(
  parameter int unsigned IDX_W = EV_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_region,
  input  logic [IDX_W-1:0] in_index,
  input  logic [31:0]      in_word,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output ex_ev_t           out_ev,
  output logic             out_err
);

  logic       wp_q, wp_d, rp_q, rp_d, filling_q, filling_d;
  logic [1:0] full_cnt_q, full_cnt_d;
  logic       in_ready_q, out_valid_q;
  logic       accept, complete, drain;
  ex_ev_t     ev0, ev1;
  logic       err0, err1;

  assign accept   = in_valid && in_ready_q;
  assign complete = accept && in_last;
  assign drain    = out_valid_q && out_ready;

  // Pointer/count bookkeeping; completion and drain may coincide.
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    filling_d  = filling_q;
    full_cnt_d = full_cnt_q;
    if (accept)   filling_d = 1'b1;
    if (complete) begin
      wp_d      = ~wp_q;
      filling_d = 1'b0;
    end
    if (drain) rp_d = ~rp_q;
    if (complete && !drain)      full_cnt_d = full_cnt_q + 2'd1;
    else if (drain && !complete) full_cnt_d = full_cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      filling_q   <= 1'b0;
      full_cnt_q  <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      filling_q   <= filling_d;
      full_cnt_q  <= full_cnt_d;
      in_ready_q  <= (full_cnt_d != 2'd2);
      out_valid_q <= (full_cnt_d != 2'd0);
    end
  end

  ev_buf_slot #(.IDX_W(IDX_W)) u_slot0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (accept && !wp_q),
    .clear_i  (!filling_q),
    .region_i (in_region),
    .index_i  (in_index),
    .word_i   (in_word),
    .ev_o     (ev0),
    .err_o    (err0)
  );

  ev_buf_slot #(.IDX_W(IDX_W)) u_slot1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (accept && wp_q),
    .clear_i  (!filling_q),
    .region_i (in_region),
    .index_i  (in_index),
    .word_i   (in_word),
    .ev_o     (ev1),
    .err_o    (err1)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ev    = rp_q ? ev1 : ev0;
  assign out_err   = rp_q ? err1 : err0;

endmodule

// File: doc/ev_word_loader.md
# ev_word_loader

Upstream feeder for the execution-event function stages (accumulate/reduce and siblings). Accepts a stream of 32-bit words, each tagged with a target region (data, shared or thread) and a word index, and assembles them into a zero-initialised `ex_ev_t`. When the last word arrives it hands the completed event downstream over a valid/ready handshake. Two event buffers run ping-pong, so one event loads while the previous one waits for the consumer.

## Interface
Parameters:
- `IDX_W`, default `EV_IDX_W` (package): width of the word index; it must cover the largest region length.

Ports:
- `clk`  in  1  clock; single clock domain, everything sampled on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  an input word is presented.
- `in_ready`  out  1  the block can accept a word this cycle.
- `in_region`  in  2  target region: `EV_REG_DATA`=0, `EV_REG_SHARED`=1, `EV_REG_THREAD`=2; 3 is reserved.
- `in_index`  in  `IDX_W`  u32 word index within the region.
- `in_word`  in  32  word value.
- `in_last`  in  1  this is the final word of the event.
- `out_valid`  out  1  a completed event is presented.
- `out_ready`  in  1  the consumer accepts the event.
- `out_ev`  out  `ex_ev_t`  the completed event.
- `out_err`  out  1  the presented event had at least one dropped word.

## Operation
- Storage:
  - Two buffers `buf[0:1]` of type `ex_ev_t`, each with an error bit.
  - Write pointer `wp`, read pointer `rp`.
  - `full_cnt` (0..2): number of completed events not yet consumed.
  - `filling` bit: the buffer at `wp` has received at least one word.
- Input acceptance: a word is accepted when `in_valid && in_ready`. `in_ready = (full_cnt != 2)`, a function of registered state only; there is no combinational path from `out_ready`.
- First word of an event (`filling==0`): the whole target buffer is cleared to 0, its error bit is cleared, then the word is written. Unwritten fields are therefore always 0.
- Writes:
  - data region: writes `buf[wp].data.u32[in_index]`.
  - shared region: writes `buf[wp].shared.u32[in_index]`.
  - thread region: writes `buf[wp].thread.u32[in_index]`; this includes the opcode words.
  - A later write to the same index overwrites the earlier one.
- Illegal words: an index at or beyond the region length (`dataLength_u32`, `sharedLength_u32`, `threadLength_u32`), or region 3, drops the word and sets the buffer error bit. The word is still accepted, and `in_last` on it is still honoured.
- Completion: an accepted word with `in_last` set completes the event: `full_cnt++`, `wp` toggles, `filling` clears.
- Output:
  - `out_valid = (full_cnt != 0)`; `out_ev = buf[rp]`; `out_err` is that buffer's error bit.
  - On `out_valid && out_ready`: `full_cnt--` and `rp` toggles.
  - `out_ev` holds stable while `out_valid && !out_ready`.
- Simultaneous completion and drain in one cycle: `full_cnt` is unchanged, both pointers toggle.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_err`=0, `out_ev`=0, `wp`=`rp`=0, `full_cnt`=0, `filling`=0, buffers 0.
- Latency:
  - Last word accepted at edge N drives `out_valid`=1 from edge N onward.
  - A single-word event is available one cycle after acceptance.
- Full condition:
  - With both buffers complete, `in_ready` drops after the edge that completed the second event.
  - It rises one cycle after the edge on which an output handshake occurs.
- Reset mid-fill: asserting `rst_n`=0 discards partial and complete events immediately (asynchronous); nothing is emitted.
- Throughput: one word per cycle sustained, one event per cycle if each event is one word and `out_ready`=1.

## Structure
- Add to the shared `EV_types`/`EV_enums` package:
  - region enum `ev_region_e` (`EV_REG_DATA/SHARED/THREAD`);
  - `EV_IDX_W`;
  - the region length constants, if not already exported.
- One sub-module: `ev_buf_slot`, a single buffer with clear-on-first-write, indexed write, range check and error bit. Instantiate it twice; the top holds the pointers, count and handshake.

## Test plan
- Single event: write data u32[0..3]=10,11,12,13, then thread opcode words encoding an accumulate/reduce with source data, count 2, destination data; last on the final word.
  - Required: `out_ev` matches exactly, `out_err`=0.
  - Chained through `accumulateReduce_f`, the result has data u32[0]=21.
- Backpressure, `out_ready`=0: two one-word events (data[0]=1, then data[0]=2).
  - Required: `in_ready`=0 after the second; a third word is not accepted.
  - Raising `out_ready` emits 1 then 2 in order; `in_ready` returns.
- Clear-on-start: event A sets data[1]=99; event B writes only data[0]=5.
  - Required: B's data[1] reads 0.
- Range error: write data index `dataLength_u32`=7 with last.
  - Required: `out_err`=1, `out_ev` all zero.
  - Region 3 write behaves the same way.
- Reset mid-fill: two words accepted, no last, then `rst_n` pulsed low.
  - Required: `out_valid` stays 0, `in_ready`=1.
  - The next event loads cleanly.
- Simultaneous: `full_cnt`=1 with `out_ready`=1 while a last word is accepted.
  - Required: `full_cnt` stays 1, the next event appears the following cycle.
